// File: rtl/bf_pkg.sv
// Shared types and helpers for the brute_force_gen candidate generator.
package bf_pkg;

    localparam int CHAR_W = 8;

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t RUN  = 2'd1;
    localparam state_t DONE = 2'd2;

    // Out-of-range characters fall back to the lowest legal character.
    function automatic logic [CHAR_W-1:0] clamp_char(
        input logic [CHAR_W-1:0] c,
        input logic [CHAR_W-1:0] lo,
        input logic [CHAR_W-1:0] hi
    );
        return ((c < lo) || (c > hi)) ? lo : c;
    endfunction

    function automatic int clamp_len(input int len, input int lo, input int hi);
        if (len < lo) return lo;
        if (len > hi) return hi;
        return len;
    endfunction

endpackage

// File: rtl/bf_char_cell.sv
// One odometer digit: holds a character, steps by inc and wraps back to start_char.
module bf_char_cell
    import bf_pkg::*;
#(
    parameter logic [CHAR_W-1:0] CHAR_HI = 8'h7A
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              load,
    input  logic [CHAR_W-1:0] load_char,
    input  logic              step,
    input  logic [CHAR_W-1:0] start_char,
    input  logic [2:0]        inc,
    output logic [CHAR_W-1:0] digit,
    output logic              wrap
);

    logic [CHAR_W:0] nxt;

    // Nine-bit sum so a step past 8'hFF is still seen as overflowing CHAR_HI.
    assign nxt  = {1'b0, digit} + {{(CHAR_W - 2){1'b0}}, inc};
    assign wrap = (nxt > {1'b0, CHAR_HI});

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            digit <= '0;
        end else if (load) begin
            digit <= load_char;
        end else if (step) begin
            digit <= wrap ? start_char : nxt[CHAR_W-1:0];
        end
    end

endmodule

// File: rtl/brute_force_gen.sv
// Synchronous password-candidate odometer with length growth and valid/ready output.
// Optional target matcher enabled by defining BF_MATCH_EN.
module brute_force_gen
    import bf_pkg::*;
#(
    parameter int                MAX_LEN = 16,
    parameter logic [CHAR_W-1:0] CHAR_LO = 8'h61,
    parameter logic [CHAR_W-1:0] CHAR_HI = 8'h7A,
    parameter int                LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      start,
    input  logic                      abort,
    input  logic [CHAR_W-1:0]         start_char,
    input  logic [2:0]                increment,
    input  logic [LEN_W-1:0]          min_len,
    input  logic [LEN_W-1:0]          max_len,
    input  logic                      out_ready,
`ifdef BF_MATCH_EN
    input  logic [CHAR_W*MAX_LEN-1:0] target,
    input  logic [LEN_W-1:0]          target_len,
    output logic                      found,
`endif
    output logic                      out_valid,
    output logic [CHAR_W*MAX_LEN-1:0] password,
    output logic [LEN_W-1:0]          word_length,
    output logic                      busy,
    output logic                      done
);

    state_t              state;
    logic [LEN_W-1:0]    len_r;
    logic [LEN_W-1:0]    max_r;
    logic [CHAR_W-1:0]   sc_r;
    logic [2:0]          inc_r;

    logic [CHAR_W-1:0]   digit [MAX_LEN];
    logic [MAX_LEN-1:0]  wrap;
    logic [MAX_LEN-1:0]  step;

    logic                accept;
    logic                start_go;
    logic                match;
    logic                top_carry;
    logic                grow;
    logic                last;
    logic                load_all;
    logic [CHAR_W-1:0]   load_char;
    logic [CHAR_W-1:0]   sc_in;
    logic [LEN_W-1:0]    min_in;
    logic [LEN_W-1:0]    max_in;

    assign sc_in  = clamp_char(start_char, CHAR_LO, CHAR_HI);
    assign min_in = LEN_W'(clamp_len(32'(min_len), 1, MAX_LEN));
    assign max_in = LEN_W'(clamp_len(32'(max_len), 32'(min_in), MAX_LEN));

    assign out_valid   = (state == RUN);
    assign busy        = (state == RUN);
    assign done        = (state == DONE);
    assign word_length = len_r;

    assign accept   = out_valid && out_ready && !abort;
    assign start_go = start && !abort && ((state == IDLE) || (state == DONE));

    // Ripple the step enable through the live digits; carry out of the top live digit ends this length.
    always_comb begin
        logic en;
        en        = accept && !match;
        top_carry = 1'b0;
        step      = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            step[i] = en && (LEN_W'(i) < len_r);
            en      = en && wrap[i];
            if (LEN_W'(i + 1) == len_r) top_carry = en;
        end
    end

    assign grow      = top_carry && (len_r < max_r);
    assign last      = top_carry && !(len_r < max_r);
    assign load_all  = start_go || grow;
    assign load_char = start_go ? sc_in : sc_r;

    for (genvar g = 0; g < MAX_LEN; g++) begin : g_cell
        bf_char_cell #(
            .CHAR_HI (CHAR_HI)
        ) u_cell (
            .clock      (clock),
            .reset_n    (reset_n),
            .load       (load_all),
            .load_char  (load_char),
            .step       (step[g]),
            .start_char (sc_r),
            .inc        (inc_r),
            .digit      (digit[g]),
            .wrap       (wrap[g])
        );
    end

    always_comb begin
        password = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if (LEN_W'(i) < len_r) password[CHAR_W*i +: CHAR_W] = digit[i];
        end
    end

`ifdef BF_MATCH_EN
    assign match = accept && (password == target) && (len_r == target_len);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            found <= 1'b0;
        end else if (abort || start_go) begin
            found <= 1'b0;
        end else if (match) begin
            found <= 1'b1;
        end
    end
`else
    assign match = 1'b0;
`endif

    // Abort has priority over start and over an accepted beat in the same cycle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            len_r <= '0;
            max_r <= '0;
            sc_r  <= '0;
            inc_r <= '0;
        end else if (abort) begin
            state <= IDLE;
            len_r <= '0;
        end else if (start_go) begin
            state <= RUN;
            len_r <= min_in;
            max_r <= max_in;
            sc_r  <= sc_in;
            inc_r <= (increment == 3'd0) ? 3'd1 : increment;
        end else if (accept) begin
            if (match || last) begin
                state <= DONE;
            end else if (grow) begin
                len_r <= len_r + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_brute_force_gen.sv
// Randomised self-checking bench for brute_force_gen with a small enumeration model.
module tb_brute_force_gen;

    localparam int         MAX_LEN = 4;
    localparam logic [7:0] CHAR_LO = 8'h61;
    localparam logic [7:0] CHAR_HI = 8'h63;
    localparam int         LEN_W   = $clog2(MAX_LEN + 1);
    localparam int         PW_W    = 8 * MAX_LEN;

    logic             clock = 1'b0;
    logic             reset_n = 1'b0;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic [7:0]       start_char = 8'h61;
    logic [2:0]       increment = 3'd1;
    logic [LEN_W-1:0] min_len = '0;
    logic [LEN_W-1:0] max_len = '0;
    logic             out_ready = 1'b0;
    logic             out_valid;
    logic [PW_W-1:0]  password;
    logic [LEN_W-1:0] word_length;
    logic             busy;
    logic             done;
`ifdef BF_MATCH_EN
    logic [PW_W-1:0]  target = '0;
    logic [LEN_W-1:0] target_len = '0;
    logic             found;
`endif

    int n_compared = 0;
    int n_mismatched = 0;

    logic [PW_W-1:0]  exp_pw [$];
    logic [LEN_W-1:0] exp_len [$];

    always #5 clock = ~clock;

    brute_force_gen #(
        .MAX_LEN (MAX_LEN),
        .CHAR_LO (CHAR_LO),
        .CHAR_HI (CHAR_HI)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .start       (start),
        .abort       (abort),
        .start_char  (start_char),
        .increment   (increment),
        .min_len     (min_len),
        .max_len     (max_len),
        .out_ready   (out_ready),
`ifdef BF_MATCH_EN
        .target      (target),
        .target_len  (target_len),
        .found       (found),
`endif
        .out_valid   (out_valid),
        .password    (password),
        .word_length (word_length),
        .busy        (busy),
        .done        (done)
    );

    // Enumerate every candidate as a base-k counter over the legal symbol set, shortest length first.
    task automatic build_model(input logic [7:0] sc, input logic [2:0] inc,
                               input logic [LEN_W-1:0] mn, input logic [LEN_W-1:0] mx);
        int s, d, lo, hi, k, total, t;
        logic [PW_W-1:0] val;
        s  = (sc < CHAR_LO || sc > CHAR_HI) ? int'(CHAR_LO) : int'(sc);
        d  = (inc == 0) ? 1 : int'(inc);
        lo = (int'(mn) < 1) ? 1 : ((int'(mn) > MAX_LEN) ? MAX_LEN : int'(mn));
        hi = (int'(mx) < lo) ? lo : ((int'(mx) > MAX_LEN) ? MAX_LEN : int'(mx));
        k  = (int'(CHAR_HI) - s) / d + 1;
        exp_pw.delete();
        exp_len.delete();
        for (int len = lo; len <= hi; len++) begin
            total = 1;
            for (int i = 0; i < len; i++) total = total * k;
            for (int n = 0; n < total; n++) begin
                val = '0;
                t = n;
                for (int i = 0; i < len; i++) begin
                    val[8*i +: 8] = 8'(s + d * (t % k));
                    t = t / k;
                end
                exp_pw.push_back(val);
                exp_len.push_back(LEN_W'(len));
            end
        end
    endtask

    task automatic applyStart(input logic [7:0] sc, input logic [2:0] inc,
                              input logic [LEN_W-1:0] mn, input logic [LEN_W-1:0] mx);
        @(negedge clock);
        start_char = sc;
        increment  = inc;
        min_len    = mn;
        max_len    = mx;
        out_ready  = 1'b0;
        start      = 1'b1;
        @(negedge clock);
        start      = 1'b0;
    endtask

    // mode 0: always ready, 1: five-cycle stall early in the run, 2: random ready.
    task automatic run_check(input string name, input logic [7:0] sc, input logic [2:0] inc,
                             input logic [LEN_W-1:0] mn, input logic [LEN_W-1:0] mx, input int mode);
        int  idx, cyc, n;
        logic rdy;
        build_model(sc, inc, mn, mx);
        n = exp_pw.size();
        applyStart(sc, inc, mn, mx);
        idx = 0;
        cyc = 0;
        while (idx < n && cyc < 4000) begin
            n_compared++;
            if (out_valid !== 1'b1 || password !== exp_pw[idx] || word_length !== exp_len[idx]) begin
                n_mismatched++;
                $display("[TB] FAIL %s beat %0d: got valid=%b pw=%h len=%0d, want valid=1 pw=%h len=%0d",
                         name, idx, out_valid, password, word_length, exp_pw[idx], exp_len[idx]);
                break;
            end
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = !(cyc >= 4 && cyc < 9);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            out_ready = rdy;
            @(negedge clock);
            if (rdy) idx++;
            cyc++;
        end
        out_ready = 1'b0;
        if (idx < n) begin
            n_compared++;
            n_mismatched++;
            $display("[TB] FAIL %s incomplete: got %0d beats, want %0d", name, idx, n);
        end
        n_compared++;
        if (done !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL %s end: got done=%b valid=%b busy=%b, want 1 0 0",
                     name, done, out_valid, busy);
        end
    endtask

    task automatic test_reset;
        #1;
        n_compared++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || password !== '0 || word_length !== '0) begin
            n_mismatched++;
            $display("[TB] FAIL reset: got valid=%b busy=%b done=%b pw=%h len=%0d, want all zero",
                     out_valid, busy, done, password, word_length);
        end
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic test_directed;
        run_check("basic", 8'h61, 3'd1, 3'd1, 3'd2, 0);
        run_check("stall", 8'h61, 3'd1, 3'd1, 3'd2, 1);
        run_check("inc2", 8'h61, 3'd2, 3'd1, 3'd1, 0);
        run_check("inc0", 8'h61, 3'd0, 3'd1, 3'd1, 0);
        // max_len is only LEN_W bits wide; 7 is the largest over-range value it can carry.
        run_check("clamp", 8'h41, 3'd1, 3'd1, 3'd7, 2);
        run_check("minzero", 8'h62, 3'd1, 3'd0, 3'd0, 0);
    endtask

    task automatic test_random;
        logic [7:0] sc;
        for (int r = 0; r < 8; r++) begin
            sc = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'(CHAR_LO + 8'($urandom_range(0, 2)));
            run_check($sformatf("rand%0d", r), sc, 3'($urandom_range(0, 7)),
                      LEN_W'($urandom_range(0, 7)), LEN_W'($urandom_range(0, 7)), 2);
        end
    endtask

    task automatic test_abort;
        applyStart(8'h61, 3'd1, 3'd1, 3'd4);
        out_ready = 1'b1;
        repeat (4) @(negedge clock);
        abort = 1'b1;
        start = 1'b1;
        @(negedge clock);
        abort = 1'b0;
        start = 1'b0;
        out_ready = 1'b0;
        n_compared++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL abort: got valid=%b busy=%b done=%b, want 0 0 0", out_valid, busy, done);
        end
        run_check("after_abort", 8'h62, 3'd1, 3'd2, 3'd2, 2);
    endtask

    task automatic test_reset_midrun;
        applyStart(8'h61, 3'd1, 3'd3, 3'd4);
        out_ready = 1'b1;
        repeat (6) @(negedge clock);
        reset_n = 1'b0;
        #1;
        n_compared++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || password !== '0 || word_length !== '0) begin
            n_mismatched++;
            $display("[TB] FAIL reset_midrun: got valid=%b busy=%b done=%b pw=%h len=%0d, want all zero",
                     out_valid, busy, done, password, word_length);
        end
        out_ready = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        run_check("after_reset", 8'h61, 3'd1, 3'd1, 3'd2, 0);
    endtask

`ifdef BF_MATCH_EN
    task automatic test_match;
        target     = 32'h0000_6162;
        target_len = 3'd2;
        applyStart(8'h61, 3'd1, 3'd1, 3'd2);
        out_ready = 1'b1;
        repeat (5) @(negedge clock);
        out_ready = 1'b0;
        repeat (3) @(negedge clock);
        n_compared++;
        if (found !== 1'b1 || done !== 1'b1 || out_valid !== 1'b0 || password !== 32'h0000_6162 || word_length !== 3'd2) begin
            n_mismatched++;
            $display("[TB] FAIL match: got found=%b done=%b valid=%b pw=%h len=%0d, want 1 1 0 00006162 2",
                     found, done, out_valid, password, word_length);
        end
        target_len = 3'd0;
        applyStart(8'h61, 3'd1, 3'd1, 3'd1);
        n_compared++;
        if (found !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL found_clear: got %b, want 0", found);
        end
        out_ready = 1'b1;
        repeat (4) @(negedge clock);
        out_ready = 1'b0;
    endtask
`endif

    initial begin
        test_reset;
        test_directed;
        test_abort;
        test_reset_midrun;
`ifdef BF_MATCH_EN
        test_match;
`endif
        test_random;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
